fifo_rd_ctrl: RTL and testbench
===============================

// Module: fifo_rd_ctrl
// PURPOSE
//  Read-side controller of the dual-clock async FIFO; counterpart of the write-side controller.
//  Owns the binary/Gray read pointer and generates rempty from the 2-flop-synchronised write pointer.
//  Drives the RAM read address and provides a first-word-fall-through output stage (valid/ready).
//  Sits entirely in the read clock domain, between the dual-port RAM and the consumer (e.g. UART TX, sys ctrl).
// PARAMETERS
//  ADDR_W  3  RAM address width; depth = 2**ADDR_W; pointers are ADDR_W+1 bits
//  DATA_W  8  data word width
//  AE_LVL  1  r_almost_empty asserts when r_level <= AE_LVL
// PORTS
//  rclk            in   1         read-domain clock
//  rrst_n          in   1         async active-low reset
//  rq2_wptr        in   ADDR_W+1  Gray write pointer, already 2-flop synchronised to rclk
//  mem_rdata       in   DATA_W    RAM word at raddr (combinational RAM read)
//  rd_ready        in   1         consumer accepts rd_data this cycle
//  raddr           out  ADDR_W    registered RAM read address
//  rptr            out  ADDR_W+1  registered Gray read pointer, to write-domain synchroniser
//  rempty          out  1         RAM holds no unread word (output register excluded)
//  rd_data         out  DATA_W    registered output word
//  rd_valid        out  1         rd_data holds a valid word
//  r_level         out  ADDR_W+1  words in RAM not yet fetched, 0..2**ADDR_W
//  r_almost_empty  out  1         r_level <= AE_LVL
// BEHAVIOUR
//  Reset: async on rrst_n low; rbin, rptr, raddr, rd_data = 0; rd_valid = 0. rempty and r_level
//    follow rq2_wptr, so rempty = 1 if rq2_wptr = 0.
//  Reset mid-operation: rd_valid drops the same instant; any word in the output register is discarded.
//  rempty = (rptr == rq2_wptr), compared in Gray, full width, combinational.
//  pop = !rempty && (!rd_valid || rd_ready).
//  On pop, at the rclk edge:
//    - rd_data <= mem_rdata (the word at the current raddr).
//    - rd_valid <= 1.
//    - rbin <= rbin+1; rptr <= bin2gray(rbin+1); raddr <= (rbin+1)[ADDR_W-1:0].
//  rd_valid && rd_ready && !pop: rd_valid <= 0; rd_data holds its value.
//  rd_valid && !rd_ready: rd_data and rd_valid hold. No pop, so no stall-driven pointer change.
//  Throughput: one word per cycle while RAM is non-empty and rd_ready = 1.
//  Latency: rq2_wptr change -> rd_valid high after exactly 1 rclk edge (show-ahead).
//  Write-to-read latency outside this block: 2 synchroniser cycles.
//  Pointer wrap: rbin wraps modulo 2**(ADDR_W+1); Gray MSB toggles per lap; no special casing.
//  r_level = gray2bin(rq2_wptr) - rbin, unsigned, ADDR_W+1 bits, modulo arithmetic.
//    - Combinational, from registered and synchronised values only.
//    - Pessimistic: lags true occupancy by the synchroniser delay.
//  rd_ready while !rd_valid is ignored.
//  Simultaneous accept plus a new word available: load and accept in the same edge; rd_valid stays 1.
//  rq2_wptr is never sampled as binary across domains; only the Gray value crosses.
// STRUCTURE
//  Shared package fifo_pkg:
//    - FIFO_ADDR_W and FIFO_DATA_W defaults.
//    - Functions bin2gray() and gray2bin(), also used by the write-side controller.
//  One sub-module: fifo_rd_outreg, the DATA_W output register with valid/ready hold logic, driven by pop.
//  Pointer, empty and level logic stay in fifo_rd_ctrl. No synchroniser inside; it lives in the top-level FIFO.
// TESTING (ADDR_W=3, DATA_W=8, AE_LVL=1)
//  1. Reset, rq2_wptr=0:
//     -> rempty=1, rd_valid=0, raddr=0, rptr=0, r_level=0, r_almost_empty=1.
//  2. rq2_wptr 0000->0001, mem_rdata=8'hA5, rd_ready=0:
//     -> next edge rd_valid=1, rd_data=A5, rptr=0001, raddr=1, rempty=1.
//     -> rd_data and rd_valid hold for 5 cycles.
//  3. rq2_wptr=gray(5), rd_ready=1 held:
//     -> 5 consecutive words; rptr sequence 0001,0011,0010,0110,0111.
//     -> rd_valid drops the cycle after the 5th accept.
//  4. Wrap: stream 20 words through, rq2_wptr advancing:
//     -> raddr wraps 7->0; rptr MSB toggles at rbin 8 and 16; data order preserved.
//  5. rq2_wptr=gray(8) (full lap) from rbin=0:
//     -> r_level=8, rempty=0, r_almost_empty=0; level decrements by 1 per pop.
//  6. Reset asserted with rd_valid=1 and r_level=4:
//     -> rd_valid=0 immediately; pointers 0; after release, rempty reflects rq2_wptr.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared async FIFO defaults and Gray/binary pointer helpers
package fifo_pkg;

  localparam int FIFO_ADDR_W = 3;
  localparam int FIFO_DATA_W = 8;

  // Helpers work on a wide container; callers zero-extend and truncate to pointer width.
  localparam int PTR_MAX_W = 16;

  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_rd_outreg.sv
// rtl/fifo_rd_outreg.sv - first-word-fall-through output register with valid/ready hold
module fifo_rd_outreg #(
  parameter int DATA_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pop_i,
  input  logic [DATA_W-1:0] din_i,
  input  logic              ready_i,
  output logic [DATA_W-1:0] data_o,
  output logic              valid_o
);

  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;

  // A pop reloads even when the held word is accepted on the same edge.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (pop_i) begin
      data_d  = din_i;
      valid_d = 1'b1;
    end else if (valid_q && ready_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = valid_q;

endmodule

// File: rtl/fifo_rd_ctrl.sv
// rtl/fifo_rd_ctrl.sv - async FIFO read-side pointer, empty/level logic and output stage
module fifo_rd_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_W = FIFO_ADDR_W,
  parameter int DATA_W = FIFO_DATA_W,
  parameter int AE_LVL = 1
) (
  input  logic              rclk,
  input  logic              rrst_n,
  input  logic [ADDR_W:0]   rq2_wptr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              rd_ready,
  output logic [ADDR_W-1:0] raddr,
  output logic [ADDR_W:0]   rptr,
  output logic              rempty,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   r_level,
  output logic              r_almost_empty
);

  localparam int PW = ADDR_W + 1;

  logic [PW-1:0]     rbin_q, rbin_d;
  logic [PW-1:0]     rptr_q, rptr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [PW-1:0]     wbin;
  logic              pop;

  // Empty compares Gray codes directly; the write pointer is only decoded for the level.
  assign rempty = (rptr_q == rq2_wptr);
  assign pop    = !rempty && (!rd_valid || rd_ready);

  always_comb begin
    rbin_d  = rbin_q;
    rptr_d  = rptr_q;
    raddr_d = raddr_q;
    if (pop) begin
      rbin_d  = rbin_q + PW'(1);
      rptr_d  = PW'(bin2gray(PTR_MAX_W'(rbin_d)));
      raddr_d = rbin_d[ADDR_W-1:0];
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin_q  <= '0;
      rptr_q  <= '0;
      raddr_q <= '0;
    end else begin
      rbin_q  <= rbin_d;
      rptr_q  <= rptr_d;
      raddr_q <= raddr_d;
    end
  end

  assign wbin           = PW'(gray2bin(PTR_MAX_W'(rq2_wptr)));
  assign r_level        = wbin - rbin_q;
  assign r_almost_empty = (r_level <= PW'(AE_LVL));
  assign raddr          = raddr_q;
  assign rptr           = rptr_q;

  fifo_rd_outreg #(
    .DATA_W (DATA_W)
  ) u_outreg (
    .clk_i   (rclk),
    .rst_ni  (rrst_n),
    .pop_i   (pop),
    .din_i   (mem_rdata),
    .ready_i (rd_ready),
    .data_o  (rd_data),
    .valid_o (rd_valid)
  );

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb/tb_fifo_rd_ctrl.sv - scoreboard bench for the async FIFO read-side controller
module tb_fifo_rd_ctrl;

  logic       rclk;
  logic       rrst_n;
  logic [3:0] rq2_wptr;
  logic [7:0] mem_rdata;
  logic       rd_ready;
  logic [2:0] raddr;
  logic [3:0] rptr;
  logic       rempty;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic [3:0] r_level;
  logic       r_almost_empty;

  logic [7:0] mem [8];
  logic [7:0] sb [$];
  logic [3:0] wbin;
  int         n_checks = 0;
  int         n_pass   = 0;
  int         n_acc    = 0;

  fifo_rd_ctrl #(
    .ADDR_W (3),
    .DATA_W (8),
    .AE_LVL (1)
  ) dut (
    .rclk           (rclk),
    .rrst_n         (rrst_n),
    .rq2_wptr       (rq2_wptr),
    .mem_rdata      (mem_rdata),
    .rd_ready       (rd_ready),
    .raddr          (raddr),
    .rptr           (rptr),
    .rempty         (rempty),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .r_level        (r_level),
    .r_almost_empty (r_almost_empty)
  );

  assign mem_rdata = mem[raddr];

  initial rclk = 1'b0;
  always #5 rclk = ~rclk;

  function automatic logic [3:0] gray4(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] d);
    mem[wbin[2:0]] = d;
    sb.push_back(d);
    wbin     = wbin + 4'd1;
    rq2_wptr = gray4(wbin);
  endtask

  task automatic do_reset();
    rrst_n   = 1'b0;
    rd_ready = 1'b0;
    wbin     = '0;
    rq2_wptr = '0;
    sb.delete();
    step();
    step();
    rrst_n = 1'b1;
    step();
  endtask

  // Transfers complete at the next rising edge; inputs only change just after rising edges.
  always @(negedge rclk) begin
    if (rrst_n && rd_valid && rd_ready) begin
      if (sb.size() == 0) begin
        check("sb_underflow", 32'(sb.size()), 32'd1);
      end else begin
        check("rd_data", rd_data, sb.pop_front());
        n_acc++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    logic [3:0] exp_g [5];
    logic [3:0] fetched, prev_rptr;
    logic [2:0] prev_raddr;
    int         start, n_written, msb_toggles, addr_wraps;

    for (int i = 0; i < 8; i++) mem[i] = '0;
    exp_g[0] = 4'b0001; exp_g[1] = 4'b0011; exp_g[2] = 4'b0010;
    exp_g[3] = 4'b0110; exp_g[4] = 4'b0111;

    // 1: reset state
    do_reset();
    check("rst_rempty", rempty, 1);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_raddr", raddr, 0);
    check("rst_rptr", rptr, 0);
    check("rst_r_level", r_level, 0);
    check("rst_ae", r_almost_empty, 1);

    // 2: first word falls through, then holds under back-pressure
    write_word(8'hA5);
    step();
    check("t2_rd_valid", rd_valid, 1);
    check("t2_rd_data", rd_data, 8'hA5);
    check("t2_rptr", rptr, 4'b0001);
    check("t2_raddr", raddr, 1);
    check("t2_rempty", rempty, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      check("t2_hold_valid", rd_valid, 1);
      check("t2_hold_data", rd_data, 8'hA5);
    end
    rd_ready = 1'b1;
    step();
    check("t2_drop_valid", rd_valid, 0);

    // 3: five back-to-back words
    do_reset();
    start = n_acc;
    for (int i = 0; i < 5; i++) write_word(8'h10 + 8'(i));
    rd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("t3_rptr", rptr, exp_g[k]);
      check("t3_valid", rd_valid, 1);
    end
    step();
    check("t3_drop_valid", rd_valid, 0);
    check("t3_accepted", n_acc - start, 5);

    // 4: wrap with random writes and consumer bubbles
    do_reset();
    start       = n_acc;
    n_written   = 0;
    msb_toggles = 0;
    addr_wraps  = 0;
    prev_rptr   = rptr;
    prev_raddr  = raddr;
    for (int cyc = 0; cyc < 400 && (n_acc - start) < 20; cyc++) begin
      if (n_written < 20 && sb.size() < 8 && $urandom_range(0, 3) != 0) begin
        write_word(8'($urandom));
        n_written++;
      end
      rd_ready = ($urandom_range(0, 3) != 0);
      step();
      fetched = 4'(n_acc - start) + 4'(rd_valid);
      check("t4_rptr", rptr, gray4(fetched));
      check("t4_raddr", raddr, fetched[2:0]);
      if (rptr[3] != prev_rptr[3]) msb_toggles++;
      if (prev_raddr == 3'd7 && raddr == 3'd0) addr_wraps++;
      prev_rptr  = rptr;
      prev_raddr = raddr;
    end
    check("t4_accepted", n_acc - start, 20);
    check("t4_msb_toggles", msb_toggles, 2);
    check("t4_addr_wraps", addr_wraps, 2);
    check("t4_final_rptr", rptr, 4'b0110);

    // 5: full lap of level
    do_reset();
    for (int i = 0; i < 8; i++) write_word(8'hC0 + 8'(i));
    #1;
    check("t5_level8", r_level, 8);
    check("t5_rempty", rempty, 0);
    check("t5_ae", r_almost_empty, 0);
    step();
    check("t5_level7", r_level, 7);
    rd_ready = 1'b1;
    for (int k = 6; k >= 0; k--) begin
      step();
      check("t5_level", r_level, 32'(k));
    end
    check("t5_ae_end", r_almost_empty, 1);
    check("t5_rempty_end", rempty, 1);
    step();
    check("t5_drained", rd_valid, 0);

    // 6: reset while a word is held
    do_reset();
    for (int i = 0; i < 5; i++) write_word(8'h60 + 8'(i));
    step();
    check("t6_pre_valid", rd_valid, 1);
    check("t6_pre_level", r_level, 4);
    rrst_n = 1'b0;
    #1;
    check("t6_rst_valid", rd_valid, 0);
    check("t6_rst_rptr", rptr, 0);
    check("t6_rst_raddr", raddr, 0);
    sb.delete();
    step();
    rrst_n = 1'b1;
    #1;
    check("t6_rempty", rempty, 0);
    check("t6_level", r_level, 5);
    for (int i = 0; i < 5; i++) sb.push_back(mem[i]);
    start    = n_acc;
    rd_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    check("t6_reread", n_acc - start, 5);
    check("t6_end_valid", rd_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
